// File: rtl/cordic_vector_iter_if.sv
// rtl/cordic_vector_iter_if.sv - strobe/sample/result bundle for the CORDIC vectoring engine
//
// Signals:
//   iter_start, iter_over : frame strobes from the timing generator
//   x_i, y_i              : signed input sample, captured on iter_start
//   err_clr               : clears the sticky sync_err flag
//   mag_o, phase_o        : magnitude (gain included) and binary-angle phase
//   valid_o               : one-cycle pulse when mag_o/phase_o update
//   sync_err              : sticky strobe-misalignment flag
// Modports: master drives strobes/samples, slave is the engine.
interface cordic_vector_iter_if #(
  parameter int DW = 16
);
  logic                 iter_start;
  logic                 iter_over;
  logic signed [DW-1:0] x_i;
  logic signed [DW-1:0] y_i;
  logic                 err_clr;
  logic        [DW:0]   mag_o;
  logic signed [15:0]   phase_o;
  logic                 valid_o;
  logic                 sync_err;

  modport master (
    output iter_start, iter_over, x_i, y_i, err_clr,
    input  mag_o, phase_o, valid_o, sync_err
  );

  modport slave (
    input  iter_start, iter_over, x_i, y_i, err_clr,
    output mag_o, phase_o, valid_o, sync_err
  );
endinterface

// File: rtl/cordic_vector_iter.sv
// rtl/cordic_vector_iter.sv - iterative CORDIC vectoring engine, one micro-rotation per clock
//
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : cordic_vector_iter_if.slave (strobes, sample in, magnitude/phase out, sync_err)
// A frame is iter_start, ITER rotation cycles, then iter_over; the result is
// published one edge after iter_over. Misaligned strobes set sync_err.
module cordic_vector_iter #(
  parameter int DW   = 16,
  parameter int ITER = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cordic_vector_iter_if.slave   bus
);

  localparam int XW = DW + 3;
  localparam int ZW = 17;
  localparam logic [4:0] ITER_L = 5'(ITER);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic signed [XW-1:0] x_q, y_q;
  logic signed [ZW-1:0] z_q;
  logic [4:0]           idx_q;
  logic [DW:0]          mag_q;
  logic [15:0]          phase_q;
  logic                 valid_q;
  logic                 err_q;

  // Quadrant fold of the incoming sample (next-state on iter_start).
  logic signed [XW-1:0] xs, ys;
  logic signed [XW-1:0] x_ld_d, y_ld_d;
  logic signed [ZW-1:0] z_ld_d;

  // One micro-rotation of the current vector (next-state in RUN).
  logic signed [XW-1:0] x_sh, y_sh;
  logic signed [ZW-1:0] atan_v;
  logic signed [XW-1:0] x_rot_d, y_rot_d;
  logic signed [ZW-1:0] z_rot_d;

  logic err_set;

  function automatic logic signed [ZW-1:0] atan_rom(input logic [3:0] i);
    case (i)
      4'd0:    atan_rom = 17'sd8192;
      4'd1:    atan_rom = 17'sd4836;
      4'd2:    atan_rom = 17'sd2555;
      4'd3:    atan_rom = 17'sd1297;
      4'd4:    atan_rom = 17'sd651;
      4'd5:    atan_rom = 17'sd326;
      4'd6:    atan_rom = 17'sd163;
      4'd7:    atan_rom = 17'sd81;
      4'd8:    atan_rom = 17'sd41;
      4'd9:    atan_rom = 17'sd20;
      4'd10:   atan_rom = 17'sd10;
      4'd11:   atan_rom = 17'sd5;
      4'd12:   atan_rom = 17'sd3;
      4'd13:   atan_rom = 17'sd1;
      4'd14:   atan_rom = 17'sd1;
      default: atan_rom = 17'sd0;
    endcase
  endfunction

  always_comb begin
    // Widen before negating so that -(-32768) is representable.
    xs = {{3{bus.x_i[DW-1]}}, bus.x_i};
    ys = {{3{bus.y_i[DW-1]}}, bus.y_i};
    if (!bus.x_i[DW-1]) begin
      x_ld_d = xs;
      y_ld_d = ys;
      z_ld_d = '0;
    end else if (!bus.y_i[DW-1]) begin
      // Left half-plane, upper: rotate by -90 deg, pre-load +pi/2.
      x_ld_d = ys;
      y_ld_d = -xs;
      z_ld_d = 17'sd16384;
    end else begin
      // Left half-plane, lower: rotate by +90 deg, pre-load -pi/2.
      x_ld_d = -ys;
      y_ld_d = xs;
      z_ld_d = -17'sd16384;
    end
  end

  always_comb begin
    x_sh   = x_q >>> idx_q[3:0];
    y_sh   = y_q >>> idx_q[3:0];
    atan_v = atan_rom(idx_q[3:0]);
    if (y_q[XW-1]) begin
      // y below axis: rotate counter-clockwise, angle accumulator goes down.
      x_rot_d = x_q - y_sh;
      y_rot_d = y_q + x_sh;
      z_rot_d = z_q - atan_v;
    end else begin
      x_rot_d = x_q + y_sh;
      y_rot_d = y_q - x_sh;
      z_rot_d = z_q + atan_v;
    end
  end

  // Any strobe that does not fit the current frame's progress is an error;
  // a start that coincides with over, or arrives mid-frame, counts too.
  always_comb begin
    err_set = 1'b0;
    if (bus.iter_start) begin
      err_set = (state_q == RUN) || bus.iter_over;
    end else if (bus.iter_over) begin
      err_set = (state_q == IDLE) || (idx_q != ITER_L);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      idx_q   <= '0;
      mag_q   <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      if (err_set) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end

      if (bus.iter_start) begin
        x_q     <= x_ld_d;
        y_q     <= y_ld_d;
        z_q     <= z_ld_d;
        idx_q   <= '0;
        state_q <= RUN;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          RUN: begin
            if (bus.iter_over) begin
              if (idx_q == ITER_L) begin
                mag_q   <= x_q[DW:0];
                // Bit 16 dropped on purpose: +pi and -pi both map to 0x8000.
                phase_q <= z_q[15:0];
                valid_q <= 1'b1;
              end
              state_q <= IDLE;
            end else if (idx_q != ITER_L) begin
              x_q   <= x_rot_d;
              y_q   <= y_rot_d;
              z_q   <= z_rot_d;
              idx_q <= idx_q + 5'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.mag_o    = mag_q;
  assign bus.phase_o  = phase_q;
  assign bus.valid_o  = valid_q;
  assign bus.sync_err = err_q;

endmodule

// File: tb/tb_cordic_vector_iter.sv
// tb/tb_cordic_vector_iter.sv - self-checking bench for cordic_vector_iter
module tb_cordic_vector_iter;

  localparam int DW   = 16;
  localparam int ITER = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_vector_iter_if #(.DW(DW)) bus ();

  cordic_vector_iter #(.DW(DW), .ITER(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int cyc = 0;
  int vcyc_last = 0;
  int vcyc_prev = 0;
  int last_mag = 0;

  int atan_t [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      vcyc_prev <= vcyc_last;
      vcyc_last <= cyc;
    end
  end

  // Reference: quadrant fold then ITER vectoring micro-rotations on plain integers.
  function automatic void ref_model(input int xi, input int yi, output int mag, output int ph);
    int x, y, z, xn, yn;
    if (xi >= 0) begin
      x = xi; y = yi; z = 0;
    end else if (yi >= 0) begin
      x = yi; y = -xi; z = 16384;
    end else begin
      x = -yi; y = xi; z = -16384;
    end
    for (int i = 0; i < ITER; i++) begin
      if (y < 0) begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_t[i];
      end else begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_t[i];
      end
      x = xn; y = yn;
    end
    mag = x & 32'h1ffff;
    ph  = z;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    tests++;
    assert (d <= tol) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d +/-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 of the frame (start sampled at the edge just passed).
  task automatic start_frame(input int xi, input int yi);
    tick();
    bus.iter_start = 1'b1;
    bus.x_i = 16'(xi);
    bus.y_i = 16'(yi);
    tick();
    bus.iter_start = 1'b0;
    bus.x_i = 16'($urandom);
    bus.y_i = 16'($urandom);
  endtask

  // From cycle 1: 16 rotation cycles, iter_over in cycle 17, result in cycle 18.
  task automatic finish_frame(input int xi, input int yi, input string tag);
    int em, ep;
    logic signed [15:0] ep16;
    ref_model(xi, yi, em, ep);
    ep16 = ep[15:0];
    repeat (16) tick();
    check({tag, ":valid_before_over"}, int'(bus.valid_o), 0);
    bus.iter_over = 1'b1;
    tick();
    bus.iter_over = 1'b0;
    check({tag, ":valid_at_18"}, int'(bus.valid_o), 1);
    check({tag, ":mag"}, int'(bus.mag_o), em);
    check({tag, ":phase"}, int'(bus.phase_o), int'(ep16));
    last_mag = em;
  endtask

  task automatic run_frame(input int xi, input int yi, input string tag);
    start_frame(xi, yi);
    finish_frame(xi, yi, tag);
  endtask

  // Loose real-valued sanity check against the ideal polar conversion.
  task automatic sanity(input int xi, input int yi, input string tag);
    real ang, mf;
    int d;
    ang = $atan2(real'(yi), real'(xi)) * 32768.0 / 3.14159265358979;
    mf  = 1.6467602 * $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
    d = int'(bus.phase_o) - $rtoi(ang);
    d = ((d % 65536) + 65536 + 32768) % 65536 - 32768;
    check_tol({tag, ":phase_ideal"}, d, 0, 48);
    check_tol({tag, ":mag_ideal"}, int'(bus.mag_o), $rtoi(mf), 8 + $rtoi(mf) / 128);
  endtask

  int dx [8] = '{1000, 0, -707, -1000, -32768, 32767, -32768, 0};
  int dy [8] = '{0, 1000, -707, 0, -32768, -32768, 32767, 0};

  initial begin
    int vc0, rx, ry;
    logic [15:0] r;

    bus.iter_start = 1'b0;
    bus.iter_over  = 1'b0;
    bus.x_i        = '0;
    bus.y_i        = '0;
    bus.err_clr    = 1'b0;

    #12;
    check("reset:mag", int'(bus.mag_o), 0);
    check("reset:phase", int'(bus.phase_o), 0);
    check("reset:valid", int'(bus.valid_o), 0);
    check("reset:sync_err", int'(bus.sync_err), 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_frame(dx[i], dy[i], $sformatf("dir%0d", i));
      if (dx[i] != 0 || dy[i] != 0) sanity(dx[i], dy[i], $sformatf("dir%0d", i));
      check($sformatf("dir%0d:sync_err", i), int'(bus.sync_err), 0);
    end

    for (int i = 0; i < 16; i++) begin
      r = 16'($urandom); rx = int'($signed(r));
      r = 16'($urandom); ry = int'($signed(r));
      run_frame(rx, ry, $sformatf("rnd%0d", i));
    end

    // Early iter_over: no result, sticky error, outputs hold.
    tick();
    vc0 = valid_cnt;
    start_frame(1234, -4321);
    repeat (9) tick();
    bus.iter_over = 1'b1;
    tick();
    bus.iter_over = 1'b0;
    check("early:valid", int'(bus.valid_o), 0);
    check("early:sync_err", int'(bus.sync_err), 1);
    check("early:mag_hold", int'(bus.mag_o), last_mag);
    repeat (10) tick();
    check("early:no_valid", valid_cnt, vc0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("clr:sync_err", int'(bus.sync_err), 0);
    run_frame(-500, 300, "after_clr");
    check("after_clr:sync_err", int'(bus.sync_err), 0);

    // Set beats clear: over in IDLE with err_clr in the same cycle.
    tick();
    bus.iter_over = 1'b1;
    bus.err_clr   = 1'b1;
    tick();
    bus.iter_over = 1'b0;
    bus.err_clr   = 1'b0;
    check("set_over_clr:sync_err", int'(bus.sync_err), 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("clr2:sync_err", int'(bus.sync_err), 0);

    // Start and over together: start wins, frame loads, error flagged.
    vc0 = valid_cnt;
    tick();
    bus.iter_start = 1'b1;
    bus.iter_over  = 1'b1;
    bus.x_i = 16'(-2000);
    bus.y_i = 16'(1500);
    tick();
    bus.iter_start = 1'b0;
    bus.iter_over  = 1'b0;
    check("same:sync_err", int'(bus.sync_err), 1);
    check("same:no_valid", int'(bus.valid_o), 0);
    finish_frame(-2000, 1500, "same");
    tick();
    check("same:one_valid", valid_cnt, vc0 + 1);

    // Restart mid-frame: only the second sample shows up.
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    start_frame(20000, 20000);
    repeat (5) tick();
    start_frame(-3000, -100);
    check("restart:sync_err", int'(bus.sync_err), 1);
    finish_frame(-3000, -100, "restart");

    // Asynchronous reset at cycle 8 of a frame.
    start_frame(7000, -7000);
    repeat (7) tick();
    check("prerst:sync_err", int'(bus.sync_err), 1);
    #2 rst = 1'b1;
    #1;
    check("arst:mag", int'(bus.mag_o), 0);
    check("arst:phase", int'(bus.phase_o), 0);
    check("arst:valid", int'(bus.valid_o), 0);
    check("arst:sync_err", int'(bus.sync_err), 0);
    vc0 = valid_cnt;
    tick();
    rst = 1'b0;
    repeat (7) tick();
    bus.iter_over = 1'b1;
    tick();
    bus.iter_over = 1'b0;
    check("arst:over_valid", int'(bus.valid_o), 0);
    check("arst:over_err", int'(bus.sync_err), 1);
    repeat (3) tick();
    check("arst:no_valid", valid_cnt, vc0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;

    // Back-to-back nominal frames: one result per 19 cycles.
    vc0 = valid_cnt;
    run_frame(100, 200, "b2b0");
    run_frame(-30000, 12345, "b2b1");
    run_frame(5, -32768, "b2b2");
    tick();
    check("b2b:count", valid_cnt, vc0 + 3);
    check("b2b:spacing", vcyc_last - vcyc_prev, 19);
    check("b2b:sync_err", int'(bus.sync_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
